// File: rtl/secret_code_gen.sv
// -----------------------------------------------------------------------------
// secret_code_gen
//
// Builds the MasterMind secret code from the game's xorshift RNG. On each
// accepted start it requests one 32-bit word at a time, takes the top
// COLOR_W bits as a candidate colour and keeps it only if it is a legal
// colour index (and, when ALLOW_REPEAT=0, not already used by an earlier
// peg). Rejection keeps the colour distribution unbiased. Discarded words
// are counted in a saturating counter.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       request a new code (only honoured when idle)
//   rng_en      one-cycle request for the RNG to advance
//   rng_word    RNG output, valid in the cycle after rng_en
//   busy        generation in progress
//   done        one-cycle pulse when the code is complete
//   code_valid  code holds a complete code
//   code        packed code, peg i at [i*COLOR_W +: COLOR_W]
//   rejects     rejected words in the current/last generation (saturating)
// -----------------------------------------------------------------------------
module secret_code_gen #(
    parameter int PEGS         = 4,
    parameter int COLORS       = 6,
    parameter int COLOR_W      = 3,
    parameter int ALLOW_REPEAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      rng_en,
    input  logic [31:0]               rng_word,
    output logic                      busy,
    output logic                      done,
    output logic                      code_valid,
    output logic [PEGS*COLOR_W-1:0]   code,
    output logic [15:0]               rejects
);

    localparam int                 IDX_W      = (PEGS > 1) ? $clog2(PEGS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(PEGS - 1);
    localparam logic [COLOR_W:0]   NUM_COLORS = (COLOR_W + 1)'(COLORS);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SAMPLE,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [COLOR_W-1:0] cand;
    logic               cand_reject;
    logic               unused_rng_bits;

    // The high bits of an xorshift word have the best statistical quality.
    assign cand            = rng_word[31 -: COLOR_W];
    assign unused_rng_bits = ^rng_word[31-COLOR_W:0];

    // Candidate rejection: out-of-range colour, or (no-repeat mode) a colour
    // already placed in one of the pegs filled so far.
    always_comb begin
        cand_reject = ({1'b0, cand} >= NUM_COLORS);
        if (ALLOW_REPEAT == 0) begin
            for (int j = 0; j < PEGS; j++) begin
                if (j < int'(idx) && code[j*COLOR_W +: COLOR_W] == cand) begin
                    cand_reject = 1'b1;
                end
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        rng_en    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                rng_en    = 1'b1;
                state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (cand_reject) begin
                    state_nxt = REQ;
                end else if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = REQ;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            rejects    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        code       <= '0;
                        code_valid <= 1'b0;
                        rejects    <= '0;
                        idx        <= '0;
                    end
                end
                SAMPLE: begin
                    if (cand_reject) begin
                        if (rejects != 16'hFFFF) begin
                            rejects <= rejects + 16'd1;
                        end
                    end else begin
                        code[int'(idx)*COLOR_W +: COLOR_W] <= cand;
                        if (idx != LAST_IDX) begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    code_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_secret_code_gen.sv
// -----------------------------------------------------------------------------
// tb_secret_code_gen
//
// Drives two instances (colours may repeat / all colours distinct) from
// per-instance word tables that stand in for the RNG. A per-instance model
// works out each generation from the word table (which words are kept, the
// resulting code and reject count) and from that the expected outputs on
// every cycle. Directed scenarios pin the model with literal results.
// -----------------------------------------------------------------------------
module tb_secret_code_gen;

    localparam int PEGS    = 4;
    localparam int COLORS  = 6;
    localparam int COLOR_W = 3;
    localparam int LIMIT   = 400;

    logic        clk;
    logic        rst_n;
    logic        start_v    [2];
    logic [31:0] rng_word_v [2];
    logic        rng_en_v   [2];
    logic        busy_v     [2];
    logic        done_v     [2];
    logic        cv_v       [2];
    logic [11:0] code_v     [2];
    logic [15:0] rej_v      [2];

    logic [31:0] words   [2][0:1023];
    int          rng_ptr [2];

    int checks = 0;
    int errors = 0;

    secret_code_gen #(
        .PEGS(PEGS), .COLORS(COLORS), .COLOR_W(COLOR_W), .ALLOW_REPEAT(1)
    ) dut_rep (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .rng_en(rng_en_v[0]),
        .rng_word(rng_word_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .code_valid(cv_v[0]), .code(code_v[0]), .rejects(rej_v[0])
    );

    secret_code_gen #(
        .PEGS(PEGS), .COLORS(COLORS), .COLOR_W(COLOR_W), .ALLOW_REPEAT(0)
    ) dut_norep (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .rng_en(rng_en_v[1]),
        .rng_word(rng_word_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .code_valid(cv_v[1]), .code(code_v[1]), .rejects(rej_v[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RNG stand-ins and per-cycle models, one per instance.
    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam bit ALLOW = (g == 0);

        initial begin : rng
            forever begin
                @(negedge clk);
                if (rng_en_v[g] === 1'b1) begin
                    @(posedge clk);
                    #1 rng_word_v[g] = words[g][rng_ptr[g] & 1023];
                    rng_ptr[g]++;
                end
            end
        end

        initial begin : model
            bit    active;
            int    k, d, n, nw, base, acc, rej, cur, c;
            bit    bad;
            int    code_pre [0:255];
            int    rej_pre  [0:255];
            int    pegs     [0:7];
            int    code_m, rej_m;
            bit    cv_m;
            string tag;
            active = 0; k = 0; d = 0; nw = 0;
            code_m = 0; rej_m = 0; cv_m = 0;
            tag = ALLOW ? "rep" : "norep";
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    active = 0; code_m = 0; rej_m = 0; cv_m = 0;
                end
                if (active) begin
                    n = (k - 1) / 2;
                    check({tag, " busy"},   32'(busy_v[g]),   32'(1));
                    check({tag, " rng_en"}, 32'(rng_en_v[g]), 32'((k % 2 == 1) && (k < d)));
                    check({tag, " done"},   32'(done_v[g]),   32'(k == d));
                    check({tag, " valid"},  32'(cv_v[g]),     32'(0));
                    check({tag, " code"},   32'(code_v[g]),   32'(code_pre[n]));
                    check({tag, " rejects"},32'(rej_v[g]),    32'(rej_pre[n]));
                end else begin
                    check({tag, " busy"},   32'(busy_v[g]),   32'(0));
                    check({tag, " rng_en"}, 32'(rng_en_v[g]), 32'(0));
                    check({tag, " done"},   32'(done_v[g]),   32'(0));
                    check({tag, " valid"},  32'(cv_v[g]),     32'(cv_m));
                    check({tag, " code"},   32'(code_v[g]),   32'(code_m));
                    check({tag, " rejects"},32'(rej_v[g]),    32'(rej_m));
                end
                if (rst_n) begin
                    if (active) begin
                        if (k == d) begin
                            active = 0;
                            cv_m   = 1;
                            code_m = code_pre[nw];
                            rej_m  = rej_pre[nw];
                        end else begin
                            k++;
                        end
                    end else if (start_v[g]) begin
                        // Play the whole generation out from the word table.
                        base = rng_ptr[g];
                        acc = 0; rej = 0; cur = 0; n = 0;
                        code_pre[0] = 0; rej_pre[0] = 0;
                        while (acc < PEGS && n < 255) begin
                            c   = int'(words[g][(base + n) & 1023] >> (32 - COLOR_W));
                            bad = (c >= COLORS);
                            if (!ALLOW) begin
                                for (int j = 0; j < acc; j++) begin
                                    if (pegs[j] == c) bad = 1;
                                end
                            end
                            if (bad) begin
                                rej++;
                            end else begin
                                cur += c * (1 << (COLOR_W * acc));
                                pegs[acc] = c;
                                acc++;
                            end
                            n++;
                            code_pre[n] = cur;
                            rej_pre[n]  = (rej > 65535) ? 65535 : rej;
                        end
                        nw = n; d = 2 * n + 1;
                        active = 1; k = 1;
                        cv_m = 0; code_m = 0; rej_m = 0;
                    end
                end
            end
        end
    end

    // Pulse start on instance g, then follow it to done; checks the done
    // latency, the rng_en pulse count and the final code/rejects.
    task automatic gen_once(input int g, input string nm, input int exp_code,
                            input int exp_rej, input int exp_lat, input int exp_pulses);
        int k;
        int pulses;
        @(posedge clk);
        #1 start_v[g] = 1'b1;
        @(posedge clk);
        #1 start_v[g] = 1'b0;
        k = 1; pulses = 0;
        while (k < LIMIT) begin
            if (rng_en_v[g]) pulses++;
            if (done_v[g]) break;
            @(posedge clk);
            #1 k++;
        end
        if (k >= LIMIT) begin
            checks++; errors++;
            $display("FAIL %s done timeout: no done within %0d cycles", nm, LIMIT);
        end
        check({nm, " latency"}, 32'(k), 32'(exp_lat));
        check({nm, " rng_en pulses"}, 32'(pulses), 32'(exp_pulses));
        @(posedge clk);
        #1;
        check({nm, " code_valid"}, 32'(cv_v[g]), 32'(1));
        check({nm, " code"}, 32'(code_v[g]), 32'(exp_code));
        check({nm, " rejects"}, 32'(rej_v[g]), 32'(exp_rej));
    endtask

    task automatic wait_done(input int g, input string nm);
        int k;
        k = 0;
        while (!done_v[g] && k < LIMIT) begin
            @(posedge clk);
            #1 k++;
        end
        if (k >= LIMIT) begin
            checks++; errors++;
            $display("FAIL %s done timeout: no done within %0d cycles", nm, LIMIT);
        end
    endtask

    task automatic check_all_zero(input string nm);
        for (int g = 0; g < 2; g++) begin
            check({nm, " rng_en"},  32'(rng_en_v[g]), 32'(0));
            check({nm, " busy"},    32'(busy_v[g]),   32'(0));
            check({nm, " done"},    32'(done_v[g]),   32'(0));
            check({nm, " valid"},   32'(cv_v[g]),     32'(0));
            check({nm, " code"},    32'(code_v[g]),   32'(0));
            check({nm, " rejects"}, 32'(rej_v[g]),    32'(0));
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int k;
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 1024; i++) words[g][i] = $urandom;
            rng_ptr[g]    = 0;
            start_v[g]    = 1'b0;
            rng_word_v[g] = 32'h0;
        end
        // Repeat-allowed instance: basic, rejection, mid-op reset, fresh run.
        words[0][0]  = 32'h00000000; words[0][1]  = 32'h40000000;
        words[0][2]  = 32'hA0000000; words[0][3]  = 32'h60000000;
        words[0][4]  = 32'hE0000000; words[0][5]  = 32'hC0000000;
        for (int i = 6; i < 10; i++) words[0][i] = 32'h20000000;
        words[0][10] = 32'hE0000000; words[0][11] = 32'h80000000;
        words[0][12] = 32'hA0000000;
        words[0][13] = 32'hC0000000; words[0][14] = 32'h20000000;
        words[0][15] = 32'h40000000; words[0][16] = 32'h60000000;
        words[0][17] = 32'h80000000;
        // Distinct-colour instance: 2, 2, 4, 2, 0, 5.
        words[1][0] = 32'h40000000; words[1][1] = 32'h40000000;
        words[1][2] = 32'h80000000; words[1][3] = 32'h40000000;
        words[1][4] = 32'h00000000; words[1][5] = 32'hA0000000;

        rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        gen_once(0, "basic", 32'h750, 0, 9, 4);
        gen_once(0, "reject", 32'h249, 2, 13, 6);
        gen_once(1, "norepeat", 32'hA22, 2, 13, 6);

        // Reset after one reject and two accepted pegs (cycle 7 is a request).
        @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        for (k = 1; k < 7; k++) begin
            @(posedge clk);
            #1;
        end
        check("midop partial code", 32'(code_v[0]), 32'h2C);
        check("midop partial rejects", 32'(rej_v[0]), 32'(1));
        #2 rst_n = 1'b0;
        #1 check_all_zero("midop reset");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        gen_once(0, "fresh", 32'h8D1, 1, 11, 5);

        // start held high through a generation.
        @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk);
        #1 wait_done(0, "held start");
        @(posedge clk);
        #1;
        check("held start idle busy", 32'(busy_v[0]), 32'(0));
        check("held start idle valid", 32'(cv_v[0]), 32'(1));
        @(posedge clk);
        #1;
        check("held start restart busy", 32'(busy_v[0]), 32'(1));
        check("held start restart valid", 32'(cv_v[0]), 32'(0));
        check("held start restart code", 32'(code_v[0]), 32'(0));
        start_v[0] = 1'b0;
        wait_done(0, "held start second");

        // Random start traffic on both instances, one reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            if (i == 700) begin
                start_v[0] = 1'b0;
                start_v[1] = 1'b0;
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end else begin
                start_v[0] = ($urandom_range(0, 3) == 0);
                start_v[1] = ($urandom_range(0, 3) == 0);
            end
        end
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        k = 0;
        while ((busy_v[0] || busy_v[1]) && k < LIMIT) begin
            @(posedge clk);
            #1 k++;
        end
        if (k >= LIMIT) begin
            checks++; errors++;
            $display("FAIL drain timeout: still busy after %0d cycles", LIMIT);
        end
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/secret_code_gen.md
Name: secret_code_gen

Overview:
- Consumes 32-bit words from the game's xorshift RNG and turns them into the MasterMind secret code: PEGS pegs, each a colour index in 0..COLORS-1.
- Drives the RNG's enable one word at a time and samples each word one cycle later.
- Maps each word to a colour by unbiased rejection sampling; optionally also rejects repeated colours.
- Sits between the RNG and the game controller, which pulses start at the beginning of each round.

Parameters:
- PEGS, 4: number of pegs in the code (2..8).
- COLORS, 6: number of legal colours; must be <= 2**COLOR_W.
- COLOR_W, 3: bits per peg.
- ALLOW_REPEAT, 1: 1 = colours may repeat; 0 = every peg has a distinct colour (requires COLORS >= PEGS).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new code; sampled only in IDLE.
- rng_en  output  1  one-cycle request for the RNG to advance.
- rng_word  input  32  RNG output; valid in the cycle after rng_en was high.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse when the code is complete.
- code_valid  output  1  high while code holds a complete code.
- code  output  PEGS*COLOR_W  packed code; peg i occupies [i*COLOR_W +: COLOR_W].
- rejects  output  16  count of rejected words in the current/last generation; saturates at 16'hFFFF.

Behaviour:
- Reset (async, rst_n low): state=IDLE; rng_en=0, busy=0, done=0, code_valid=0, code=0, rejects=0, peg index=0.
- States: IDLE, REQ, SAMPLE, DONE.
- IDLE:
  - start=1 -> REQ.
  - On that edge: code<=0, code_valid<=0, rejects<=0, idx<=0, busy<=1.
- REQ: rng_en=1 (combinational from state, exactly one cycle) -> SAMPLE.
- SAMPLE: rng_en=0. Candidate c = rng_word[31:32-COLOR_W], the top bits, which have the best xorshift quality.
  - Reject if c >= COLORS.
  - If ALLOW_REPEAT=0, also reject if c equals any peg j < idx.
  - Reject: rejects += 1 (saturating) -> REQ.
  - Accept: code[idx] <= c.
    - idx == PEGS-1 -> DONE.
    - Otherwise idx += 1 -> REQ.
- DONE: done=1 for this one cycle, code_valid<=1, busy<=0 -> IDLE.
- Latency: with no rejects, done is asserted 2*PEGS+1 cycles after the edge that accepted start. Each rejection adds 2 cycles.
- Stalling: no timeout. Forward progress relies on the RNG eventually producing an acceptable word.
- start while busy (REQ/SAMPLE/DONE): ignored, no queuing.
- start in the same cycle as DONE: ignored. It is accepted on the next cycle in IDLE.
- code and code_valid hold indefinitely in IDLE until the next accepted start.
- Reset mid-generation: immediate return to reset values. A partial code is never exposed with code_valid=1.
- Exactly one rng_en pulse per RNG word consumed. rng_en is never high in IDLE, SAMPLE or DONE.

Test Plan:
- Reset: hold rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately; state IDLE after release.
- Basic (PEGS=4, COLORS=6, COLOR_W=3):
  - Stimulus: start pulse; bench RNG model returns 32'h00000000, 32'h40000000, 32'hA0000000, 32'h60000000 on successive rng_en.
  - Response: code=12'h750, rejects=0, done exactly 9 cycles after start edge, code_valid=1, rng_en pulsed 4 times.
- Rejection:
  - Stimulus: words 32'hE0000000 (7), 32'hC0000000 (6), then 0x20000000, 0x20000000, 0x20000000, 0x20000000.
  - Response: code=12'h249, rejects=2, done at cycle 13.
- No-repeat (ALLOW_REPEAT=0):
  - Stimulus: words 2, 2, 4, 2, 0, 5 (top bits).
  - Response: code pegs [2,4,0,5]=12'hA22, rejects=2.
- Busy/start:
  - Stimulus: start held high throughout a generation.
  - Response: a second generation begins only after returning to IDLE; code_valid drops on that start edge.
- Reset mid-op:
  - Stimulus: assert rst_n=0 after 2 accepted pegs.
  - Response: code=0, code_valid=0; a subsequent start yields a full fresh code with rejects restarted at 0.
